// File: rtl/digrev_pkg.sv
// ---------------------------------------------------------------------------
// digrev_pkg
//   Shared definitions for the 81-point base-3 digit-reversal ping-pong buffer.
//   - N_FRAME / NUM_TRITS : frame length (3^4) and digits per index
//   - bank_state_e        : life cycle of one ping-pong bank
//   - trit_inc()          : increments a packed 4-trit counter (2 bits/trit)
//   - rev3()              : converts a packed trit counter to its digit-reversed
//                           linear address
// ---------------------------------------------------------------------------
package digrev_pkg;

    localparam int N_FRAME   = 81;
    localparam int NUM_TRITS = 4;
    localparam int TRIT_W    = 2 * NUM_TRITS;
    localparam int REV_W     = 7;

    // Counter value of the final sample of a frame (every trit == 2).
    localparam logic [TRIT_W-1:0] TRIT_LAST = 8'b1010_1010;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Trit 0 sits in bits [1:0] and is the least significant digit.
    function automatic logic [TRIT_W-1:0] trit_inc(input logic [TRIT_W-1:0] t);
        logic carry;
        trit_inc = t;
        carry    = 1'b1;
        for (int i = 0; i < NUM_TRITS; i++) begin
            if (carry) begin
                if (t[2*i +: 2] == 2'd2) begin
                    trit_inc[2*i +: 2] = 2'd0;
                end else begin
                    trit_inc[2*i +: 2] = t[2*i +: 2] + 2'd1;
                    carry              = 1'b0;
                end
            end
        end
    endfunction

    // Horner evaluation starting from the least significant trit makes it the
    // most significant digit of the result: t0*27 + t1*9 + t2*3 + t3.
    function automatic logic [REV_W-1:0] rev3(input logic [TRIT_W-1:0] t);
        rev3 = '0;
        for (int i = 0; i < NUM_TRITS; i++) begin
            rev3 = rev3 * 7'd3 + {5'd0, t[2*i +: 2]};
        end
    endfunction

endpackage

// File: rtl/digrev_bank.sv
// ---------------------------------------------------------------------------
// digrev_bank
//   One ping-pong bank: simple dual-port RAM, one write and one registered
//   synchronous read per cycle. Contents are not reset.
//   Ports: clk, wr_en/wr_addr/wr_data (write port),
//          rd_en/rd_addr (read issue), rd_data (valid the cycle after rd_en)
// ---------------------------------------------------------------------------
module digrev_bank #(
    parameter int DEPTH = 81,
    parameter int DW    = 36,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/digrev81_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// digrev81_pingpong_ctrl
//   Two-bank ping-pong buffer that writes each 81-sample frame in base-3
//   digit-reversed address order and reads it back linearly, so the output
//   stream is the digit-reversed permutation of the input stream.
//   Ports: clk, rst (sync, active-high)
//          in_valid/in_ready/in_re/in_im : input stream, flush drops a partial frame
//          out_valid/out_ready/out_re/out_im/out_last : output stream
//          bank_full[b] : bank b holds a complete frame (FULL or DRAINING)
// ---------------------------------------------------------------------------
module digrev81_pingpong_ctrl
    import digrev_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int N     = 81
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_last,
    output logic [1:0]              bank_full
);

    localparam int AW = $clog2(N);
    localparam int DW = 2 * WIDTH;
    localparam int SW = DW + 1;     // {last, im, re}

    bank_state_e       bank_state_q [2];
    bank_state_e       bank_state_d [2];
    logic              wsel_q, wsel_d;
    logic              rsel_q, rsel_d;
    logic [TRIT_W-1:0] wtrit_q, wtrit_d;
    logic [AW-1:0]     raddr_q, raddr_d;

    // Read data in flight out of the RAM register this cycle.
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              rd_bank_q, rd_bank_d;

    logic [SW-1:0]     skid_q [2];
    logic [SW-1:0]     skid_d [2];
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic [SW-1:0]     out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic              wr_fire, wr_en, rd_issue, rd_avail;
    logic              load_out, skid_pop, skid_push;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     bank_rdata [2];
    logic [SW-1:0]     rd_sample;

    assign in_ready = (bank_state_q[wsel_q] == BANK_EMPTY) ||
                      (bank_state_q[wsel_q] == BANK_FILLING);
    assign wr_fire  = in_valid && in_ready;
    assign wr_en    = wr_fire && !flush;
    assign wr_addr  = AW'(rev3(wtrit_q));

    // A read may only be issued if everything already headed for the skid
    // (its contents plus the word landing from the RAM) leaves a slot free.
    assign rd_avail = (bank_state_q[rsel_q] == BANK_FULL) ||
                      (bank_state_q[rsel_q] == BANK_DRAINING);
    assign rd_issue = rd_avail && ((skid_cnt_q + {1'b0, rd_valid_q}) < 2'd2);

    assign rd_sample = {rd_last_q, bank_rdata[rd_bank_q]};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            digrev_bank #(
                .DEPTH (N),
                .DW    (DW),
                .AW    (AW)
            ) u_bank (
                .clk     (clk),
                .wr_en   (wr_en && (wsel_q == gi[0])),
                .wr_addr (wr_addr),
                .wr_data ({in_im, in_re}),
                .rd_en   (rd_issue && (rsel_q == gi[0])),
                .rd_addr (raddr_q),
                .rd_data (bank_rdata[gi])
            );
            assign bank_full[gi] = (bank_state_q[gi] == BANK_FULL) ||
                                   (bank_state_q[gi] == BANK_DRAINING);
        end
    endgenerate

    // Bank bookkeeping. The write side only touches an EMPTY/FILLING bank and
    // the read side only a FULL/DRAINING one, so the two never collide.
    always_comb begin
        bank_state_d = bank_state_q;
        wsel_d       = wsel_q;
        rsel_d       = rsel_q;
        wtrit_d      = wtrit_q;
        raddr_d      = raddr_q;
        rd_valid_d   = rd_issue;
        rd_last_d    = rd_last_q;
        rd_bank_d    = rd_bank_q;

        if (flush) begin
            wtrit_d = '0;
            if (bank_state_q[wsel_q] == BANK_FILLING) begin
                bank_state_d[wsel_q] = BANK_EMPTY;
            end
        end else if (wr_fire) begin
            if (wtrit_q == TRIT_LAST) begin
                bank_state_d[wsel_q] = BANK_FULL;
                wsel_d               = !wsel_q;
                wtrit_d              = '0;
            end else begin
                bank_state_d[wsel_q] = BANK_FILLING;
                wtrit_d              = trit_inc(wtrit_q);
            end
        end

        if (rd_issue) begin
            rd_bank_d = rsel_q;
            rd_last_d = (raddr_q == AW'(N - 1));
            if (raddr_q == AW'(N - 1)) begin
                bank_state_d[rsel_q] = BANK_EMPTY;
                rsel_d               = !rsel_q;
                raddr_d              = '0;
            end else begin
                bank_state_d[rsel_q] = BANK_DRAINING;
                raddr_d              = raddr_q + AW'(1);
            end
        end
    end

    // Output register fed first from the skid (oldest data), else straight
    // from the RAM; RAM words that cannot go out this edge enter the skid.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        load_out    = !out_valid_q || out_ready;
        skid_pop    = load_out && (skid_cnt_q != 2'd0);
        skid_push   = rd_valid_q && !(load_out && (skid_cnt_q == 2'd0));

        if (load_out) begin
            if (skid_cnt_q != 2'd0) begin
                out_valid_d = 1'b1;
                out_d       = skid_q[0];
            end else if (rd_valid_q) begin
                out_valid_d = 1'b1;
                out_d       = rd_sample;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        skid_cnt_d = skid_cnt_q - {1'b0, skid_pop};
        if (skid_pop) begin
            skid_d[0] = skid_q[1];
        end
        if (skid_push) begin
            skid_d[skid_cnt_d[0]] = rd_sample;
            skid_cnt_d            = skid_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            wsel_q          <= 1'b0;
            rsel_q          <= 1'b0;
            wtrit_q         <= '0;
            raddr_q         <= '0;
            rd_valid_q      <= 1'b0;
            rd_last_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            skid_q[0]       <= '0;
            skid_q[1]       <= '0;
            skid_cnt_q      <= 2'd0;
            out_q           <= '0;
            out_valid_q     <= 1'b0;
        end else begin
            bank_state_q    <= bank_state_d;
            wsel_q          <= wsel_d;
            rsel_q          <= rsel_d;
            wtrit_q         <= wtrit_d;
            raddr_q         <= raddr_d;
            rd_valid_q      <= rd_valid_d;
            rd_last_q       <= rd_last_d;
            rd_bank_q       <= rd_bank_d;
            skid_q          <= skid_d;
            skid_cnt_q      <= skid_cnt_d;
            out_q           <= out_d;
            out_valid_q     <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_q[WIDTH-1:0];
    assign out_im    = out_q[DW-1:WIDTH];
    assign out_last  = out_q[DW];

endmodule

// File: tb/tb_digrev81_pingpong_ctrl.sv
module tb_digrev81_pingpong_ctrl;

    localparam int W = 18;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic                flush = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                out_last;
    logic [1:0]          bank_full;

    digrev81_pingpong_ctrl #(.WIDTH(W), .N(81)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic                last;
    } samp_t;

    samp_t exp_q[$];
    samp_t part[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last80_edge = 0;
    int n_out = 0;
    int rmode = 0;          // 0: out_ready=1, 1: out_ready=0, 2: random
    bit lat_en = 0;
    bit gap_en = 0;
    int gap_base = 0;
    int gaps = 0;
    bit ir_en = 0;
    int ir_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Digit reversal from plain base-3 arithmetic.
    function automatic int rev3_ref(input int k);
        return (k % 3) * 27 + ((k / 3) % 3) * 9 + ((k / 9) % 3) * 3 + (k / 27);
    endfunction

    // Reference model: collect accepted samples; a complete frame becomes 81
    // expected outputs in digit-reversed order.
    initial begin
        samp_t frame [81];
        samp_t s;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                part.delete();
            end else if (flush) begin
                part.delete();
            end else if (in_valid && in_ready) begin
                s.re = in_re; s.im = in_im; s.last = 1'b0;
                part.push_back(s);
                if (part.size() == 81) begin
                    for (int k = 0; k < 81; k++) frame[rev3_ref(k)] = part[k];
                    for (int j = 0; j < 81; j++) begin
                        s = frame[j];
                        s.last = (j == 80);
                        exp_q.push_back(s);
                    end
                    part.delete();
                    last80_edge = cyc + 1;
                end
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        bit    prev_stall = 0;
        bit    prev_valid = 0;
        samp_t held;
        samp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                prev_valid = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", {out_re, out_im, out_last}, held);
                end
                if (lat_en && out_valid && !prev_valid) begin
                    chk("first_out_latency", cyc - last80_edge, 2);
                    lat_en = 0;
                end
                if (ir_en && !in_ready) ir_drop++;
                if (gap_en && (n_out - gap_base) > 0 && (n_out - gap_base) < 324 && !out_valid)
                    gaps++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_re", out_re, e.re);
                        chk("out_im", out_im, e.im);
                        chk("out_last", out_last, e.last);
                    end
                    n_out++;
                end
                prev_stall = out_valid && !out_ready;
                held       = {out_re, out_im, out_last};
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic signed [W-1:0] r, input logic signed [W-1:0] i);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        in_valid = 1'b1; in_re = r; in_im = i;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 3000);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_bank_full"}, bank_full, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int base;
        int n;
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_bank_full", bank_full, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // One frame re=k, im=-k; checks order, out_last and latency
        rmode = 0;
        lat_en = 1;
        for (int k = 0; k < 81; k++) send(W'(k), -W'(k));
        wait_drain();
        chk("latency_seen", lat_en, 0);

        // Four back-to-back frames at full rate
        gap_en = 1; gap_base = n_out; gaps = 0; ir_en = 1; ir_drop = 0;
        for (int k = 0; k < 324; k++) send_rand();
        ir_en = 0;
        wait_drain();
        gap_en = 0;
        chk("stream_in_ready_drops", ir_drop, 0);
        chk("stream_gaps", gaps, 0);
        chk("stream_outputs", n_out - gap_base, 324);

        // Downstream stalled: two frames fit, the third is back-pressured
        rmode = 1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 162; k++) send_rand();
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stalled_in_ready", in_ready, 0);
        chk("stalled_bank_full", bank_full, 3);
        @(posedge clk);
        #1;
        rmode = 0;
        for (int k = 0; k < 81; k++) send_rand();
        wait_drain();

        // Random downstream back-pressure and random input gaps
        rmode = 2;
        for (int k = 0; k < 162; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_rand();
        end
        wait_drain();
        rmode = 0;

        // Flush after 40 samples, with a write offered in the flush cycle
        for (int k = 0; k < 40; k++) send_rand();
        flush = 1'b1; in_valid = 1'b1; in_re = W'($urandom); in_im = W'($urandom);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 81; k++) send_rand();
        wait_drain();

        // Reset while sample 30 is on the output
        base = n_out;
        for (int k = 0; k < 81; k++) send_rand();
        n = 0;
        while ((n_out - base) < 30 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_sample_30", n_out - base, 30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("midrst");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midrst_quiet", out_valid, 0);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/digrev81_pingpong_ctrl.md
DIGREV81_PINGPONG_CTRL -- requirements
Module: digrev81_pingpong_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 18, meaning bit width of each real/imag sample.
REQ-002 SHALL have parameter N, default 81, meaning frame length; fixed at 3^4.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input sample valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_re, in_im  input  WIDTH each  signed input sample.
REQ-008 SHALL have port flush  input  1  discard the partially written frame.
REQ-009 SHALL have port out_valid  output  1  output sample valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts output.
REQ-011 SHALL have port out_re, out_im  output  WIDTH each  signed reordered sample.
REQ-012 SHALL have port out_last  output  1  marks output sample index 80.
REQ-013 SHALL have port bank_full  output  2  per-bank FULL/DRAINING status.

Function
REQ-014 SHALL hold two banks (0,1), each of N complex entries, each bank in one of EMPTY, FILLING, FULL, DRAINING.
REQ-015 SHALL write to bank wsel; a sample transfers on in_valid && in_ready.
REQ-016 SHALL write the k-th accepted sample (k=0..80) to address rev3(k): rev3 reverses the 4 base-3 digits of k (1->27, 3->9, 9->3, 27->1, 80->80).
REQ-017 SHALL derive rev3(k) from a 4-trit counter incremented per accepted sample; no 81-entry lookup table.
REQ-018 SHALL move bank wsel EMPTY->FILLING on its first write and FILLING->FULL on write k=80; on the same edge, toggle wsel and clear the write counter.
REQ-019 SHALL drive in_ready = 1 iff bank wsel is EMPTY or FILLING; both banks FULL/DRAINING -> in_ready=0.
REQ-020 SHALL read bank rsel linearly (addresses 0..80) when it is FULL; FULL->DRAINING on first read issue, DRAINING->EMPTY after address 80 is issued, then toggle rsel.
REQ-021 SHALL use a synchronous-read memory with a registered output stage plus a 2-entry skid, giving 1 sample/cycle under continuous out_ready.
REQ-022 SHALL assert out_valid for the first sample of a frame exactly 2 clocks after the edge that accepted input sample 80, provided out_valid was low and out_ready high.
REQ-023 SHALL hold out_re, out_im, out_last stable while out_valid && !out_ready.
REQ-024 SHALL assert out_last only with the output sample at linear address 80.
REQ-025 SHALL sustain gapless streaming: with in_valid and out_ready continuously high, in_ready never drops after reset.
REQ-026 SHALL allow a write to bank A and a read of bank B in the same cycle, including bank A becoming FULL while bank B becomes EMPTY.
REQ-027 SHALL, on flush, return bank wsel FILLING->EMPTY and clear the write counter next edge, leaving the reading bank untouched; flush overrides a same-cycle write.
REQ-028 SHALL drive bank_full[b] = 1 while bank b is FULL or DRAINING.

Reset
REQ-029 SHALL, on rst, set both banks EMPTY, wsel=rsel=0, write/read counters 0, skid empty.
REQ-030 SHALL, on rst, drive out_valid=0, out_last=0, out_re=out_im=0, bank_full=0; in_ready=1 from the first cycle after rst deasserts.
REQ-031 SHALL leave memory contents unreset; rst mid-frame discards all frames in flight.

Structure
REQ-032 SHALL place N, trit count (4), the bank-state enum and the rev3 function in shared package digrev_pkg.
REQ-033 SHALL instantiate sub-module digrev_bank (1-write/1-read synchronous RAM of N x 2*WIDTH), twice.

Verification
REQ-034 SHALL cover: one frame in=k (re=k, im=-k), out_ready=1 -> outputs in order re=0,27,54,9,36,...,80; out_last on 81st; first out_valid 2 clocks after last input.
REQ-035 SHALL cover: 4 back-to-back frames, in_valid and out_ready held high -> in_ready constant 1, 324 outputs with no gaps after first latency.
REQ-036 SHALL cover: out_ready=0 throughout, 3 frames offered -> in_ready drops after 162 accepts, bank_full=2'b11, no data lost once out_ready=1.
REQ-037 SHALL cover: random out_ready 50% -> output matches rev3 order, values stable while stalled.
REQ-038 SHALL cover: flush after 40 samples, then full frame -> only the full frame appears, correctly reordered.
REQ-039 SHALL cover: rst asserted while draining sample 30 -> next cycle out_valid=0, bank_full=0, in_ready=1.
